// File: rtl/gate_ctrl.sv
// ----------------------------------------------------------------------------
// gate_ctrl
// Controls a single-lane gate that carries both entry and exit traffic.
// In IDLE it arbitrates the two requests, giving exit priority. It then opens
// the gate in the granted direction and waits for that direction's pass pulse
// from the two-sensor direction detector, or for the open window to time out.
// Finally it holds the gate closed for a fixed guard time.
// It also keeps the lane occupancy count and the full/empty flags.
//
// Optional feature (macro GATE_STATS_EN):
//   Adds the free-running counters total_in and total_out, which wrap at 8 bits.
//   Adds a saturating timeout counter, timeout_cnt.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_in       level, vehicle waiting at entry
//   req_out      level, vehicle waiting at exit
//   pass_in      1-cycle pulse, entry traversal complete
//   pass_out     1-cycle pulse, exit traversal complete
//   gate_open    registered actuator command
//   dir          registered: 00 none, 01 entry, 10 exit
//   occupancy    current vehicle count
//   full         occupancy == MAX_OCC
//   empty        occupancy == 0
//   timeout_err  1-cycle registered pulse when an open window expires
//   total_in     (GATE_STATS_EN) successful entries, wraps
//   total_out    (GATE_STATS_EN) successful exits, wraps
//   timeout_cnt  (GATE_STATS_EN) number of timeouts, saturates at 255
// ----------------------------------------------------------------------------
module gate_ctrl #(
    parameter int MAX_OCC     = 10,
    parameter int CNT_W       = 4,
    parameter int OPEN_TICKS  = 8,
    parameter int CLOSE_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             pass_in,
    input  logic             pass_out,
    output logic             gate_open,
    output logic [1:0]       dir,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
`ifdef GATE_STATS_EN
    output logic [7:0]       total_in,
    output logic [7:0]       total_out,
    output logic [7:0]       timeout_cnt,
`endif
    output logic             timeout_err
);

    // One timer serves both the open window and the close guard time.
    localparam int TMAX = (OPEN_TICKS > CLOSE_TICKS) ? OPEN_TICKS : CLOSE_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]    OPEN_LAST  = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0]    CLOSE_LAST = TW'(CLOSE_TICKS - 1);
    localparam logic [CNT_W-1:0] OCC_MAX    = CNT_W'(MAX_OCC);

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_IN   = 2'b01;
    localparam logic [1:0] DIR_OUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    // Clamping guards: the arbitration already prevents over- and under-flow.
    // These keep the count sane even if the detector misbehaves.
    function automatic logic [CNT_W-1:0] occ_sat_inc(input logic [CNT_W-1:0] v);
        return (v >= OCC_MAX) ? OCC_MAX : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] occ_sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

`ifdef GATE_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction
`endif

    assign full  = (occupancy == OCC_MAX);
    assign empty = (occupancy == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            occupancy   <= '0;
            gate_open   <= 1'b0;
            dir         <= DIR_NONE;
            timeout_err <= 1'b0;
`ifdef GATE_STATS_EN
            total_in    <= 8'd0;
            total_out   <= 8'd0;
            timeout_cnt <= 8'd0;
`endif
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Exit first: it frees capacity, so a waiting entry can follow.
                    if (req_out && !empty) begin
                        state     <= OPEN_OUT;
                        gate_open <= 1'b1;
                        dir       <= DIR_OUT;
                        timer     <= '0;
                    end else if (req_in && !full) begin
                        state     <= OPEN_IN;
                        gate_open <= 1'b1;
                        dir       <= DIR_IN;
                        timer     <= '0;
                    end
                end

                OPEN_IN: begin
                    // A pass on the last open cycle still counts; no timeout then.
                    if (pass_in) begin
                        occupancy <= occ_sat_inc(occupancy);
`ifdef GATE_STATS_EN
                        total_in  <= total_in + 8'd1;
`endif
                        state     <= CLOSE;
                        gate_open <= 1'b0;
                        dir       <= DIR_NONE;
                        timer     <= '0;
                    end else if (timer == OPEN_LAST) begin
                        timeout_err <= 1'b1;
`ifdef GATE_STATS_EN
                        timeout_cnt <= sat_inc8(timeout_cnt);
`endif
                        state       <= CLOSE;
                        gate_open   <= 1'b0;
                        dir         <= DIR_NONE;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                OPEN_OUT: begin
                    if (pass_out) begin
                        occupancy <= occ_sat_dec(occupancy);
`ifdef GATE_STATS_EN
                        total_out <= total_out + 8'd1;
`endif
                        state     <= CLOSE;
                        gate_open <= 1'b0;
                        dir       <= DIR_NONE;
                        timer     <= '0;
                    end else if (timer == OPEN_LAST) begin
                        timeout_err <= 1'b1;
`ifdef GATE_STATS_EN
                        timeout_cnt <= sat_inc8(timeout_cnt);
`endif
                        state       <= CLOSE;
                        gate_open   <= 1'b0;
                        dir         <= DIR_NONE;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                CLOSE: begin
                    // Guard time; requests and passes are deliberately ignored.
                    if (timer == CLOSE_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    gate_open <= 1'b0;
                    dir       <= DIR_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gate_ctrl
// Directed-vector bench for gate_ctrl.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same
// point, so every check sees the state that the preceding edge produced.
// ----------------------------------------------------------------------------
module tb_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in, req_out, pass_in, pass_out;
    logic       gate_open;
    logic [1:0] dir;
    logic [3:0] occupancy;
    logic       full, empty, timeout_err;
`ifdef GATE_STATS_EN
    logic [7:0] total_in, total_out, timeout_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    gate_ctrl #(
        .MAX_OCC     (10),
        .CNT_W       (4),
        .OPEN_TICKS  (8),
        .CLOSE_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .req_out     (req_out),
        .pass_in     (pass_in),
        .pass_out    (pass_out),
        .gate_open   (gate_open),
        .dir         (dir),
        .occupancy   (occupancy),
        .full        (full),
        .empty       (empty),
`ifdef GATE_STATS_EN
        .total_in    (total_in),
        .total_out   (total_out),
        .timeout_cnt (timeout_cnt),
`endif
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete entry cycle from IDLE: grant, pass, then the 3-cycle close back to IDLE.
    task automatic do_entry();
        req_in = 1'b1; step();
        req_in = 1'b0; pass_in = 1'b1; step();
        pass_in = 1'b0;
        step(); step(); step();
    endtask

    // One complete exit cycle from IDLE, the same sequence as do_entry for the exit side.
    task automatic do_exit();
        req_out = 1'b1; step();
        req_out = 1'b0; pass_out = 1'b1; step();
        pass_out = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        rst = 1'b1; req_in = 1'b0; req_out = 1'b0; pass_in = 1'b0; pass_out = 1'b0;
        #12;
        check_val("rst_gate",  gate_open,   0);
        check_val("rst_dir",   dir,         0);
        check_val("rst_occ",   occupancy,   0);
        check_val("rst_full",  full,        0);
        check_val("rst_empty", empty,       1);
        check_val("rst_tmo",   timeout_err, 0);
        rst = 1'b0;

        // Entry grant latency, pass after 3 open cycles, close time
        req_in = 1'b1; step();
        check_val("t1_gate", gate_open, 1);
        check_val("t1_dir",  dir,       1);
        step(); step();
        pass_in = 1'b1; req_in = 1'b0; step();
        pass_in = 1'b0;
        check_val("t1_occ",    occupancy, 1);
        check_val("t1_closed", gate_open, 0);
        check_val("t1_dir0",   dir,       0);
        step(); check_val("t1_close1", gate_open, 0);
        step(); check_val("t1_close2", gate_open, 0);
        step(); check_val("t1_idle",   gate_open, 0);
        req_in = 1'b1; step();
        check_val("t1_regrant", gate_open, 1);
        req_in = 1'b0; pass_in = 1'b1; step();
        pass_in = 1'b0;
        check_val("t1_occ2", occupancy, 2);
        step(); step(); step();

        // Exit has priority, then the pending entry is granted
        req_in = 1'b1; req_out = 1'b1; step();
        check_val("t2_dir_out", dir, 2);
        req_out = 1'b0; pass_out = 1'b1; step();
        pass_out = 1'b0;
        check_val("t2_occ", occupancy, 1);
        step(); step(); step();
        check_val("t2_idle_gate", gate_open, 0);
        step();
        check_val("t2_dir_in", dir, 1);
        req_in = 1'b0; pass_in = 1'b1; step();
        pass_in = 1'b0;
        step(); step(); step();
        check_val("t2_occ2", occupancy, 2);

        // Fill to capacity; entry is refused while full
        repeat (8) do_entry();
        check_val("t3_occ10", occupancy, 10);
        check_val("t3_full",  full,      1);
        req_in = 1'b1;
        repeat (4) step();
        check_val("t3_nogrant", gate_open, 0);
        check_val("t3_nodir",   dir,       0);
        req_out = 1'b1; step();
        check_val("t3_exit", dir, 2);
        req_out = 1'b0; pass_out = 1'b1; step();
        pass_out = 1'b0;
        check_val("t3_occ9",   occupancy, 9);
        check_val("t3_notful", full,      0);
        step(); step(); step(); step();
        check_val("t3_entry", dir, 1);

        // Timeout with no pass: error flag on the 8th open edge
        req_in = 1'b0;
        repeat (7) step();
        check_val("t4_still_open", gate_open,   1);
        check_val("t4_no_tmo",     timeout_err, 0);
        step();
        check_val("t4_tmo",      timeout_err, 1);
        check_val("t4_gate0",    gate_open,   0);
        check_val("t4_occ_same", occupancy,   9);
        step();
        check_val("t4_tmo_once", timeout_err, 0);
        step(); step();

        // A pass on the same edge as the timeout wins
        req_in = 1'b1; step();
        req_in = 1'b0;
        repeat (7) step();
        pass_in = 1'b1; step();
        pass_in = 1'b0;
        check_val("t5_no_tmo", timeout_err, 0);
        check_val("t5_occ10",  occupancy,   10);
        step(); step(); step();

        // Asynchronous reset while the gate is open
        req_out = 1'b1; step();
        check_val("t6_open", gate_open, 1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_gate0", gate_open, 0);
        check_val("t6_dir0",  dir,       0);
        check_val("t6_occ0",  occupancy, 0);
        req_out = 1'b0;
        #1 rst = 1'b0;

        // Exit request and pass pulses while empty
        req_out = 1'b1; step(); step();
        check_val("t7_nogrant", gate_open, 0);
        check_val("t7_empty",   empty,     1);
        req_out = 1'b0; pass_out = 1'b1; step();
        pass_out = 1'b0;
        check_val("t7_occ0", occupancy, 0);
        pass_in = 1'b1; step();
        pass_in = 1'b0;
        check_val("t7_idle_passin", occupancy, 0);

`ifdef GATE_STATS_EN
        rst = 1'b1; #2 rst = 1'b0;
        check_val("st_rst_in", total_in, 0);
        step();
        repeat (255) begin
            do_entry();
            do_exit();
        end
        check_val("st_in255",  total_in,  255);
        check_val("st_out255", total_out, 255);
        do_entry();
        do_exit();
        check_val("st_in_wrap",  total_in,  0);
        check_val("st_out_wrap", total_out, 0);
        req_in = 1'b1; step();
        req_in = 1'b0;
        repeat (8) step();
        check_val("st_tmo_cnt", timeout_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_ctrl.md
Name: gate_ctrl

Overview:
- Sequencing controller for a single-lane gate shared by entry and exit traffic.
- Arbitrates entry/exit requests, opens the gate, waits for the direction detector's pass pulse or a timeout, then closes it.
- Maintains the occupancy count and full/empty flags.
- Sits between the two-sensor direction detector (pass pulses) and the gate actuator.

Parameters:
- MAX_OCC, 10: capacity; entry is refused while occupancy == MAX_OCC.
- CNT_W, 4: occupancy width; must satisfy 2^CNT_W > MAX_OCC.
- OPEN_TICKS, 8: cycles the gate stays open waiting for a pass pulse before timeout.
- CLOSE_TICKS, 3: cycles spent in CLOSE before a new grant is possible.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  1  level; vehicle waiting at entry.
- req_out  in  1  level; vehicle waiting at exit.
- pass_in  in  1  one-cycle pulse from detector: entry traversal complete.
- pass_out  in  1  one-cycle pulse from detector: exit traversal complete.
- gate_open  out  1  actuator command, registered.
- dir  out  2  00 none, 01 entry granted, 10 exit granted; registered.
- occupancy  out  CNT_W  current count.
- full  out  1  occupancy == MAX_OCC.
- empty  out  1  occupancy == 0.
- timeout_err  out  1  one-cycle pulse when an open window expires without a pass.

Behaviour:
- Reset (async, rst=1):
  - State IDLE, timer 0, occupancy 0.
  - gate_open=0, dir=00, timeout_err=0; full=0, empty=1.
- States: IDLE, OPEN_IN, OPEN_OUT, CLOSE.
- IDLE arbitration, evaluated each edge:
  - Exit has priority. If req_out=1 and empty=0, go to OPEN_OUT.
  - Otherwise, if req_in=1 and full=0, go to OPEN_IN.
  - Otherwise, stay in IDLE.
  - req_out while empty is ignored. req_in while full is ignored; the request stays pending.
- Latency: a request sampled at edge k gives gate_open=1 and dir valid after edge k (one cycle).
- On entry to OPEN_*: timer cleared. It increments each cycle in OPEN_*.
- OPEN_IN:
  - pass_in=1: occupancy+1, go to CLOSE.
  - Else if timer == OPEN_TICKS-1: timeout_err=1 for one cycle, go to CLOSE, occupancy unchanged.
  - pass_out is ignored in this state.
- OPEN_OUT: mirror of OPEN_IN using pass_out and occupancy-1; pass_in is ignored.
- Pass pulse and timeout on the same edge: the pass wins and no timeout_err is raised.
- CLOSE:
  - gate_open=0, dir=00; timer counts 0..CLOSE_TICKS-1, then the FSM returns to IDLE.
  - All requests and passes are ignored.
- Occupancy saturates at 0 and MAX_OCC as a guard; it never wraps.
- full and empty are decoded combinationally from the registered occupancy.
- A pass pulse in IDLE has no effect.
- Reset asserted mid-operation returns everything to reset values immediately. The gate closes asynchronously.
- Timer width: clog2(max(OPEN_TICKS, CLOSE_TICKS)) bits, shared between OPEN and CLOSE.

Optional Feature:
- Macro: GATE_STATS_EN.
- Defined:
  - Adds output ports total_in[7:0] and total_out[7:0].
  - Each counts successful entry/exit passes; 8-bit wrap from 255 to 0.
  - Both reset to 0.
  - Adds output timeout_cnt[7:0], which saturates at 255.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold req_in=1 and pulse pass_in 3 cycles after the grant -> gate_open=1 one cycle after request; occupancy=1 after the pass; gate_open=0 for 3 cycles; back in IDLE.
- req_in and req_out both high in IDLE with occupancy=2 -> dir=10 (exit); after pass_out occupancy=1; then entry granted on the next IDLE.
- Fill to 10 entries, then hold req_in -> full=1, no grant, gate_open stays 0; one exit then makes full=0 and the entry is granted.
- req_in granted with no pass for 8 cycles -> timeout_err pulses once on the 8th open cycle; occupancy unchanged; CLOSE then IDLE.
- req_out with occupancy=0 -> no grant, empty=1 held; pass_out in IDLE -> occupancy stays 0.
- Assert rst during OPEN_IN -> gate_open=0 and dir=00 without waiting for a clock edge; occupancy=0.
- With GATE_STATS_EN: 256 entry/exit pairs -> total_in=0 after wrap.
